// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader that fills program memory and releases the core
//
// Purpose:
//   Receives a frame LEN_LO, LEN_HI (word count N), then 4*N data bytes (each word LSB first).
//   It assembles the bytes into 32-bit words and writes them to program memory at word
//   addresses 0..N-1. The core is held in reset until the image is complete, then released.
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       synchronous active-high reset
//   in_valid_i    in_data_i holds a byte
//   in_data_i     stream byte
//   in_ready_o    a byte is accepted this cycle when in_valid_i is also high
//   mem_we_o      program-memory write strobe, one cycle per word
//   mem_addr_o    word address of the write
//   mem_wdata_o   instruction word
//   core_reset_o  core reset, high while loading or after an error
//   loaded_o      image complete, core running
//   error_o       bad length or checksum; sticky until reset
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  core_reset_o,
  output logic                  loaded_o,
  output logic                  error_o
);

  // One extra bit so that N = 2**ADDR_WIDTH (a completely full memory) is representable.
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state_q;
  logic [7:0]    len_lo_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] word_idx_q;
  logic [1:0]    byte_cnt_q;
  // The first three bytes of the current word; the newest byte sits in the top lane.
  logic [23:0]   word_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  logic          accept;
  logic [15:0]   len_d;
  logic [IW-1:0] word_idx_d;
  logic          last_word;

  assign in_ready_o = !reset_i && (state_q == S_LEN0 || state_q == S_LEN1 ||
                                   state_q == S_DATA || state_q == S_CSUM);
  assign accept     = in_valid_i && in_ready_o;
  assign len_d      = {in_data_i, len_lo_q};
  assign word_idx_d = word_idx_q + IW'(1);
  assign last_word  = (word_idx_d == len_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_LEN0;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      core_reset_o <= 1'b1;
      loaded_o     <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse.
      mem_we_o <= 1'b0;
      case (state_q)
        S_LEN0: begin
          if (accept) begin
            len_lo_q <= in_data_i;
            state_q  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            if (len_d == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              state_q <= S_DONE;
`endif
            end else if ({1'b0, len_d} > CAPACITY) begin
              state_q <= S_ERR;
              error_o <= 1'b1;
            end else begin
              len_q   <= len_d[IW-1:0];
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= {in_data_i, word_q[23:8]};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ in_data_i;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_we_o    <= 1'b1;
              mem_addr_o  <= word_idx_q[ADDR_WIDTH-1:0];
              mem_wdata_o <= {in_data_i, word_q};
              word_idx_q  <= word_idx_d;
              if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_q <= S_CSUM;
`else
                state_q <= S_DONE;
`endif
              end
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (in_data_i == csum_q) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_ERR;
              error_o <= 1'b1;
            end
          end
        end
`endif
        // The final write is on the bus during DONE. The core is released only on the
        // edge that leaves DONE, so it cannot fetch before that write has landed.
        S_DONE: begin
          state_q      <= S_RUN;
          core_reset_o <= 1'b0;
          loaded_o     <= 1'b1;
        end
        S_RUN: state_q <= S_RUN;
        S_ERR: state_q <= S_ERR;
        default: state_q <= S_LEN0;
      endcase
    end
  end

endmodule
